// File: rtl/adc_trigcap_if.sv
// Sample-word stream in and capture-RAM write port out, bundled for adc_trigcap.
// The slave modport is the capture controller's view; master is the producer/RAM side.
interface adc_trigcap_if #(
  parameter int ADDR_W = 14
);
  logic [63:0]       i_data;
  logic              i_valid;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [63:0]       o_wr_data;
  logic [7:0]        o_byteen;

  modport slave (
    input  i_data, i_valid,
    output o_wr_en, o_wr_addr, o_wr_data, o_byteen
  );

  modport master (
    output i_data, i_valid,
    input  o_wr_en, o_wr_addr, o_wr_data, o_byteen
  );
endinterface

// File: rtl/adc_trigcap.sv
// Triggered capture into a circular RAM: pre-trigger history, fixed post-trigger
// length, level irq held until acknowledged.
//
// state | meaning
// IDLE  | no writes, waiting for arm
// ARMED | writing history, looking for a rising threshold crossing
// POST  | writing post-trigger words until POST_WORDS reached
// DONE  | capture complete, irq high until ack
module adc_trigcap #(
  parameter int ADDR_W     = 14,
  parameter int PRE_WORDS  = 4096,
  parameter int POST_WORDS = 8192
) (
  input  logic              i_50clk,
  input  logic              i_nreset,
  adc_trigcap_if.slave      bus,
  input  logic [13:0]       i_threshold,
  input  logic              i_arm,
  input  logic              i_ack,
  output logic [ADDR_W-1:0] o_trig_addr,
  output logic              o_wrapped,
  output logic              o_irq,
  output logic [1:0]        o_state
);
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0]     PRE_C  = CW'(PRE_WORDS);
  localparam logic [CW-1:0]     POST_C = CW'(POST_WORDS);
  localparam logic [CW-1:0]     ONE_C  = CW'(1);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]     pre_q;
  logic [CW-1:0]     post_q, post_d;
  logic              prev_above_q;
  logic              wrapped_q;
  logic [ADDR_W-1:0] trig_addr_q;
  logic              irq_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [63:0]       wr_data_q;
  logic [7:0]        byteen_q;
  logic              above_d;
  logic              trig_d;

  always_comb begin
    above_d = (bus.i_data[13:0]  >= i_threshold) ||
              (bus.i_data[29:16] >= i_threshold) ||
              (bus.i_data[45:32] >= i_threshold) ||
              (bus.i_data[61:48] >= i_threshold);
    trig_d  = (pre_q == PRE_C) && above_d && !prev_above_q;
    ptr_d   = ptr_q + ONE_A;
    post_d  = post_q + ONE_C;
  end

  always_ff @(posedge i_50clk or negedge i_nreset) begin
    if (!i_nreset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      pre_q        <= '0;
      post_q       <= '0;
      prev_above_q <= 1'b1;
      wrapped_q    <= 1'b0;
      trig_addr_q  <= '0;
      irq_q        <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      byteen_q     <= 8'h00;
    end else begin
      wr_en_q  <= 1'b0;
      byteen_q <= 8'h00;
      case (state_q)
        S_IDLE: begin
          if (i_arm) begin
            state_q      <= S_ARMED;
            ptr_q        <= '0;
            pre_q        <= '0;
            wrapped_q    <= 1'b0;
            trig_addr_q  <= '0;
            prev_above_q <= 1'b1;
          end
        end
        S_ARMED: begin
          if (bus.i_valid) begin
            wr_en_q      <= 1'b1;
            byteen_q     <= 8'hFF;
            wr_addr_q    <= ptr_q;
            wr_data_q    <= bus.i_data;
            ptr_q        <= ptr_d;
            prev_above_q <= above_d;
            if (&ptr_q) wrapped_q <= 1'b1;
            if (pre_q != PRE_C) pre_q <= pre_q + ONE_C;
            if (trig_d) begin
              trig_addr_q <= ptr_q;
              post_q      <= ONE_C;
              if (POST_WORDS == 1) begin
                state_q <= S_DONE;
                irq_q   <= 1'b1;
              end else begin
                state_q <= S_POST;
              end
            end
          end
        end
        S_POST: begin
          if (bus.i_valid) begin
            wr_en_q   <= 1'b1;
            byteen_q  <= 8'hFF;
            wr_addr_q <= ptr_q;
            wr_data_q <= bus.i_data;
            ptr_q     <= ptr_d;
            post_q    <= post_d;
            if (&ptr_q) wrapped_q <= 1'b1;
            if (post_d == POST_C) begin
              state_q <= S_DONE;
              irq_q   <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (i_ack) begin
            state_q <= S_IDLE;
            irq_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_wr_en   = wr_en_q;
  assign bus.o_wr_addr = wr_addr_q;
  assign bus.o_wr_data = wr_data_q;
  assign bus.o_byteen  = byteen_q;
  assign o_trig_addr   = trig_addr_q;
  assign o_wrapped     = wrapped_q;
  assign o_irq         = irq_q;
  assign o_state       = state_q;
endmodule

// File: tb/tb_adc_trigcap.sv
// Directed scenarios for adc_trigcap with a write-port scoreboard.
module tb_adc_trigcap;
  localparam int AW = 4;

  logic        clk;
  logic        nreset;
  logic [13:0] threshold;
  logic        arm;
  logic        ack;
  logic [AW-1:0] trig_addr;
  logic        wrapped;
  logic        irq;
  logic [1:0]  state;

  adc_trigcap_if #(.ADDR_W(AW)) bus ();

  adc_trigcap #(.ADDR_W(AW), .PRE_WORDS(4), .POST_WORDS(6)) dut (
    .i_50clk    (clk),
    .i_nreset   (nreset),
    .bus        (bus.slave),
    .i_threshold(threshold),
    .i_arm      (arm),
    .i_ack      (ack),
    .o_trig_addr(trig_addr),
    .o_wrapped  (wrapped),
    .o_irq      (irq),
    .o_state    (state)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [63:0]   data;
    logic [1:0]    st;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] w4(input int a, input int b, input int c, input int d);
    return {2'b00, 14'(d), 2'b00, 14'(c), 2'b00, 14'(b), 2'b00, 14'(a)};
  endfunction

  // Monitor: every write strobe must match the next expected entry.
  always @(negedge clk) begin
    if (bus.o_wr_en === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual_addr=%0d expected=none", bus.o_wr_addr);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_addr", 64'(bus.o_wr_addr), 64'(e.addr));
        chk("wr_data", bus.o_wr_data, e.data);
        chk("state_at_wr", 64'(state), 64'(e.st));
        chk("irq_at_wr", 64'(irq), 64'(e.st == 2'd3));
        chk("byteen", 64'(bus.o_byteen), 64'hFF);
      end
    end
  end

  task automatic send(input logic [63:0] d, input bit wr, input logic [AW-1:0] a,
                      input logic [1:0] st);
    bus.i_data  = d;
    bus.i_valid = 1'b1;
    if (wr) q.push_back('{a, d, st});
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  // n words starting at addr a; lanes 0/2 = lane, lanes 1/3 small varying values.
  task automatic send_n(input int n, input int lane, input logic [AW-1:0] a,
                        input logic [1:0] st, input bit wr);
    logic [AW-1:0] ad;
    ad = a;
    for (int i = 0; i < n; i++) begin
      send(w4(lane, i + 2, lane, 3 * i + 1), wr, ad, st);
      ad = ad + 1'b1;
    end
  endtask

  task automatic idle();
    bus.i_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm(input bit with_valid);
    arm = 1'b1;
    if (with_valid) begin
      bus.i_valid = 1'b1;
      bus.i_data  = w4(7, 7, 7, 7);
    end
    @(posedge clk);
    #1;
    arm = 1'b0;
    bus.i_valid = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_wr_en"}, 64'(bus.o_wr_en), 64'd0);
    chk({tag, "_wr_addr"}, 64'(bus.o_wr_addr), 64'd0);
    chk({tag, "_wr_data"}, bus.o_wr_data, 64'd0);
    chk({tag, "_byteen"}, 64'(bus.o_byteen), 64'd0);
    chk({tag, "_trig_addr"}, 64'(trig_addr), 64'd0);
    chk({tag, "_wrapped"}, 64'(wrapped), 64'd0);
    chk({tag, "_irq"}, 64'(irq), 64'd0);
    chk({tag, "_state"}, 64'(state), 64'd0);
  endtask

  initial begin
    nreset      = 1'b0;
    arm         = 1'b0;
    ack         = 1'b0;
    threshold   = 14'd1000;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    nreset = 1'b1;
    @(posedge clk);
    #1;

    // Valid words with no arm: no writes.
    send_n(3, 1500, 4'd0, 2'd0, 1'b0);
    idle();
    chk_reset_outs("noarm");

    // Pre-count gating, then trigger at address 5.
    pulse_arm(1'b1);
    chk("arm_state", 64'(state), 64'd1);
    send_n(3, 1, 4'd0, 2'd1, 1'b1);
    send(w4(1, 1, 1000, 1), 1'b1, 4'd3, 2'd1);
    send(w4(1, 1, 1, 1), 1'b1, 4'd4, 2'd1);
    send(w4(1, 1, 1000, 1), 1'b1, 4'd5, 2'd2);
    send_n(4, 50, 4'd6, 2'd2, 1'b1);
    send(w4(9, 8, 7, 6), 1'b1, 4'd10, 2'd3);
    idle();
    chk("s2_trig_addr", 64'(trig_addr), 64'd5);
    chk("s2_irq", 64'(irq), 64'd1);
    chk("s2_wrapped", 64'(wrapped), 64'd0);
    send_n(2, 1, 4'd0, 2'd3, 1'b0);
    idle();
    pulse_ack();
    chk("s2_ack_state", 64'(state), 64'd0);
    chk("s2_ack_irq", 64'(irq), 64'd0);

    // Already high at arm: no trigger until a genuine rise; pointer wraps first.
    pulse_arm(1'b0);
    send_n(16, 2000, 4'd0, 2'd1, 1'b1);
    send_n(4, 2000, 4'd0, 2'd1, 1'b1);
    send(w4(1, 1, 1, 1), 1'b1, 4'd4, 2'd1);
    send(w4(1, 1, 1, 3000), 1'b1, 4'd5, 2'd2);
    send_n(4, 20, 4'd6, 2'd2, 1'b1);
    send(w4(5, 5, 5, 5), 1'b1, 4'd10, 2'd3);
    idle();
    chk("s3_trig_addr", 64'(trig_addr), 64'd5);
    chk("s3_wrapped", 64'(wrapped), 64'd1);
    chk("s3_irq", 64'(irq), 64'd1);
    pulse_ack();

    // Trigger at 13: post writes wrap 13,14,15,0,1,2.
    pulse_arm(1'b0);
    chk("s4_wrapped_cleared", 64'(wrapped), 64'd0);
    send_n(13, 1, 4'd0, 2'd1, 1'b1);
    send(w4(999, 1000, 0, 0), 1'b1, 4'd13, 2'd2);
    send_n(4, 30, 4'd14, 2'd2, 1'b1);
    send(w4(2, 4, 6, 8), 1'b1, 4'd2, 2'd3);
    idle();
    chk("s4_trig_addr", 64'(trig_addr), 64'd13);
    chk("s4_wrapped", 64'(wrapped), 64'd1);
    chk("s4_state", 64'(state), 64'd3);

    // Arm together with ack in DONE: ack wins, arm dropped.
    arm = 1'b1;
    ack = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0;
    ack = 1'b0;
    chk("s5_state_idle", 64'(state), 64'd0);
    chk("s5_irq", 64'(irq), 64'd0);
    idle();
    chk("s5_still_idle", 64'(state), 64'd0);
    pulse_arm(1'b0);
    chk("s5_armed", 64'(state), 64'd1);
    send_n(5, 1, 4'd0, 2'd1, 1'b1);
    send(w4(1000, 0, 0, 0), 1'b1, 4'd5, 2'd2);
    send(w4(3, 3, 3, 3), 1'b1, 4'd6, 2'd2);
    idle();
    chk("s6_post_state", 64'(state), 64'd2);

    // Reset mid-POST.
    nreset = 1'b0;
    #1;
    chk_reset_outs("midrst");
    @(posedge clk);
    #1;
    nreset = 1'b1;
    @(posedge clk);
    #1;
    send_n(2, 2000, 4'd0, 2'd0, 1'b0);
    idle();
    chk("post_rst_state", 64'(state), 64'd0);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_trigcap.md
# adc_trigcap

Triggered capture controller downstream of the ADC packing/write stage. It consumes the 64-bit packed sample words (four 14-bit samples per word) and their single-cycle valid strobe. It writes them into a circular capture RAM with pre-trigger history, stops after a fixed post-trigger length, and holds an interrupt to the processor until acknowledged.

## Interface
Parameters:
- ADDR_W, 14, capture RAM address width; DEPTH = 2**ADDR_W words
- PRE_WORDS, 4096, minimum words written after arm before a trigger is accepted
- POST_WORDS, 8192, words written from the trigger word inclusive; PRE_WORDS + POST_WORDS ≤ DEPTH, POST_WORDS ≥ 1

Ports:
- i_50clk  in  1  clock
- i_nreset  in  1  reset, asynchronous, active-low
- i_data  in  64  packed word; lanes [13:0],[29:16],[45:32],[61:48], unsigned
- i_valid  in  1  one-cycle strobe qualifying i_data
- i_threshold  in  14  trigger level; quasi-static, sampled each valid
- i_arm  in  1  one-cycle pulse, start capture
- i_ack  in  1  one-cycle pulse, clear done/irq
- o_wr_en  out  1  RAM write strobe
- o_wr_addr  out  ADDR_W  RAM write address
- o_wr_data  out  64  RAM write data
- o_byteen  out  8  8'hFF when o_wr_en, else 8'h00
- o_trig_addr  out  ADDR_W  address of trigger word
- o_wrapped  out  1  write pointer has wrapped since arm
- o_irq  out  1  capture complete, level
- o_state  out  2  current state encoding

## Operation
- States: IDLE=0, ARMED=1, POST=2, DONE=3.
- IDLE: no writes. i_arm → ARMED; write pointer, pre counter, o_wrapped and o_trig_addr cleared to 0.
- ARMED: every i_valid writes the word at the pointer, then the pointer increments mod DEPTH. The pointer passing DEPTH-1→0 sets o_wrapped (sticky until next arm). Pre counter increments per write and saturates at PRE_WORDS.
- Trigger condition, evaluated per valid word: pre counter == PRE_WORDS (before this word), any lane ≥ i_threshold, and the previous valid word had all lanes < i_threshold. The previous-word flag resets to "above" on arm, so a signal already high at arm cannot trigger.
- On trigger: the word is written, o_trig_addr = its address, post counter = 1, state → POST. If POST_WORDS == 1, go directly to DONE.
- POST: each valid write increments the post counter. The write making the count equal POST_WORDS is the last one; state → DONE. Last address = (o_trig_addr + POST_WORDS − 1) mod DEPTH.
- DONE: no writes; o_irq = 1. i_ack → IDLE. i_arm is ignored.
- i_arm is ignored outside IDLE. i_ack is ignored outside DONE.
- Counters are ADDR_W+1 bits wide. Address arithmetic wraps mod DEPTH.

## Timing
- Reset values: o_wr_en 0, o_wr_addr 0, o_wr_data 0, o_byteen 0, o_trig_addr 0, o_wrapped 0, o_irq 0, o_state IDLE. All internal counters and flags are 0; previous-word flag is "above".
- All outputs are registered. An accepted i_valid at edge N produces o_wr_en/addr/data at edge N+1, for exactly one cycle.
- i_valid in the same cycle as an accepted i_arm is not written. Writing starts with the first valid after entering ARMED.
- State change on trigger is visible at edge N+1, together with the trigger word's write. o_trig_addr updates on the same edge.
- The last POST write and o_state = DONE / o_irq = 1 appear on the same edge.
- i_ack at edge N: o_irq = 0 and o_state = IDLE at edge N+1.
- Back-to-back i_valid on every cycle must be supported with no drops.
- Reset asserted mid-capture clears everything immediately. No further writes occur; o_irq drops without ack.

## Test plan
Bench parameters: ADDR_W=4, PRE_WORDS=4, POST_WORDS=6.
- Reset, then valid words without arm → no o_wr_en; all outputs at reset values.
- Arm with threshold=1000. Send 3 words with lanes=1, then 1 word with lane2=1000 → no trigger (pre not satisfied). Send 1 word at 1 and 1 word at 1000 → trigger at addr 5; writes continue to addr 10; o_irq rises with the addr-10 write.
- Arm while input is already ≥ threshold for 20 words → no trigger. Drop to 1, then rise → trigger on the rise. Pointer passes 15→0 before the trigger → o_wrapped = 1.
- Trigger at addr 13 → post writes 13,14,15,0,1,2; DONE after addr 2.
- Assert i_arm and i_ack together in DONE → IDLE, irq cleared, no arm. An i_arm pulse next cycle → ARMED with pointer 0.
- Assert reset during POST → outputs return to reset values immediately; no write occurs on the following valid.
